// File: rtl/counter_bank.sv
// Bank of independent up/down counters with boundary-event reporting.
// Events queue one deep per channel and leave through a round-robin valid/ready port.
module counter_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       down,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic                      clear,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       terminal,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [CW-1:0]             evt_channel,
    output logic                      evt_down,
    output logic [7:0]                drop_count
);

    localparam logic [WIDTH-1:0] MAX_VALUE = '1;

    logic [CHANNELS-1:0] event_hit;
    logic [CHANNELS-1:0] drop_hit;
    logic [CHANNELS-1:0] grant_onehot;
    logic [CHANNELS-1:0] pend_reg, pend_next;
    logic [CHANNELS-1:0] pend_dir_reg, pend_dir_next;
    logic [CHANNELS-1:0] terminal_reg;
    logic                evt_valid_reg, evt_down_reg;
    logic [CW-1:0]       evt_channel_reg, rr_ptr_reg;
    logic [7:0]          drop_reg, drop_next;
    logic                out_free, grant_found;
    logic [CW-1:0]       grant_ch;
    int                  drop_total;

    assign out_free = ~evt_valid_reg | evt_ready;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] count_reg;
            logic             boundary;

            assign boundary       = down[gi] ? (count_reg == '0) : (count_reg == MAX_VALUE);
            assign event_hit[gi]  = en[gi] & ~load[gi] & ~clear & boundary;
            assign grant_onehot[gi] = grant_found & (grant_ch == CW'(gi));
            // A grant frees the slot this cycle, so a coincident event refills it instead of dropping.
            assign drop_hit[gi]   = event_hit[gi] & pend_reg[gi] & ~grant_onehot[gi];
            assign pend_next[gi]  = ~clear & (event_hit[gi] | (pend_reg[gi] & ~grant_onehot[gi]));
            assign pend_dir_next[gi] = (event_hit[gi] & ~drop_hit[gi]) ? down[gi] : pend_dir_reg[gi];
            assign count[gi*WIDTH +: WIDTH] = count_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (clear) begin
                    count_reg <= '0;
                end else if (load[gi]) begin
                    count_reg <= load_value[gi*WIDTH +: WIDTH];
                end else if (en[gi] && !(SATURATE != 0 && event_hit[gi])) begin
                    count_reg <= down[gi] ? count_reg - 1'b1 : count_reg + 1'b1;
                end
            end
        end
    endgenerate

    // Round-robin search begins one past the most recently granted channel.
    always_comb begin
        int            idx_i;
        logic [CW-1:0] idx_c;
        grant_found = 1'b0;
        grant_ch    = '0;
        idx_i       = 0;
        idx_c       = '0;
        if (out_free && !clear) begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx_i = int'(rr_ptr_reg) + k;
                if (idx_i >= CHANNELS) idx_i = idx_i - CHANNELS;
                idx_c = CW'(idx_i);
                if (!grant_found && pend_reg[idx_c]) begin
                    grant_found = 1'b1;
                    grant_ch    = idx_c;
                end
            end
        end
    end

    always_comb begin
        drop_total = int'(drop_reg) + $countones(drop_hit);
        drop_next  = (drop_total > 255) ? 8'hFF : drop_total[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg        <= '0;
            pend_dir_reg    <= '0;
            terminal_reg    <= '0;
            drop_reg        <= '0;
            evt_valid_reg   <= 1'b0;
            evt_channel_reg <= '0;
            evt_down_reg    <= 1'b0;
            rr_ptr_reg      <= '0;
        end else begin
            pend_reg     <= pend_next;
            pend_dir_reg <= pend_dir_next;
            terminal_reg <= event_hit;
            drop_reg     <= clear ? 8'h00 : drop_next;
            if (out_free) begin
                evt_valid_reg <= grant_found;
                if (grant_found) begin
                    evt_channel_reg <= grant_ch;
                    evt_down_reg    <= pend_dir_reg[grant_ch];
                    rr_ptr_reg      <= (grant_ch == CW'(CHANNELS - 1)) ? '0 : grant_ch + 1'b1;
                end
            end
        end
    end

    assign terminal    = terminal_reg;
    assign evt_valid   = evt_valid_reg;
    assign evt_channel = evt_channel_reg;
    assign evt_down    = evt_down_reg;
    assign drop_count  = drop_reg;

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: a wrap instance and a saturate instance share stimulus
// and are compared against an array-based reference model; events are checked on handshake.
module tb_counter_bank;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   en = '0, down = '0, load = '0;
    logic [CH*W-1:0] load_value = '0;
    logic            clear = 1'b0, evt_ready = 1'b0;

    logic [CH*W-1:0] count_w, count_s;
    logic [CH-1:0]   term_w, term_s;
    logic            valid_w, valid_s, dn_w, dn_s;
    logic [1:0]      ch_w, ch_s;
    logic [7:0]      drop_w, drop_s;

    always #5 clk = ~clk;

    counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .down(down), .load(load), .load_value(load_value),
        .clear(clear), .count(count_w), .terminal(term_w), .evt_valid(valid_w),
        .evt_ready(evt_ready), .evt_channel(ch_w), .evt_down(dn_w), .drop_count(drop_w));

    counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .down(down), .load(load), .load_value(load_value),
        .clear(clear), .count(count_s), .terminal(term_s), .evt_valid(valid_s),
        .evt_ready(evt_ready), .evt_channel(ch_s), .evt_down(dn_s), .drop_count(drop_s));

    // Reference state, index 0 = wrap instance, 1 = saturate instance.
    int m_cnt  [2][CH];
    bit m_pend [2][CH];
    bit m_pdir [2][CH];
    bit m_term [2][CH];
    bit m_valid[2];
    int m_och  [2];
    bit m_odn  [2];
    int m_ptr  [2];
    int m_drop [2];
    int exp_q0[$];
    int exp_q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < CH; i++) begin
                m_cnt[k][i] = 0; m_pend[k][i] = 0; m_pdir[k][i] = 0; m_term[k][i] = 0;
            end
            m_valid[k] = 0; m_och[k] = 0; m_odn[k] = 0; m_ptr[k] = 0; m_drop[k] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic push_exp(input int k, input int v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    // One clock edge of behaviour, from the current inputs and the previous model state.
    task automatic model_step(input int k);
        bit ev[CH];
        bit free_out, found;
        int g, nd, c, j;
        free_out = !m_valid[k] || evt_ready;
        for (int i = 0; i < CH; i++) begin
            c = m_cnt[k][i];
            ev[i] = en[i] && !load[i] && !clear && (down[i] ? (c == 0) : (c == 255));
        end
        found = 0; g = 0;
        if (free_out && !clear) begin
            for (int s = 0; s < CH; s++) begin
                j = (m_ptr[k] + s) % CH;
                if (!found && m_pend[k][j]) begin found = 1; g = j; end
            end
        end
        if (free_out) begin
            m_valid[k] = found;
            if (found) begin
                m_och[k] = g;
                m_odn[k] = m_pdir[k][g];
                m_pend[k][g] = 0;
                m_ptr[k] = (g + 1) % CH;
                push_exp(k, g * 2 + int'(m_odn[k]));
            end
        end
        nd = 0;
        for (int i = 0; i < CH; i++) begin
            if (ev[i]) begin
                if (m_pend[k][i]) nd++;
                else begin m_pend[k][i] = 1; m_pdir[k][i] = down[i]; end
            end
        end
        m_drop[k] = (m_drop[k] + nd > 255) ? 255 : m_drop[k] + nd;
        for (int i = 0; i < CH; i++) begin
            m_term[k][i] = ev[i];
            if (clear) m_cnt[k][i] = 0;
            else if (load[i]) m_cnt[k][i] = int'(load_value[i*W +: W]);
            else if (en[i] && !(ev[i] && k == 1)) m_cnt[k][i] = (m_cnt[k][i] + (down[i] ? 255 : 1)) % 256;
        end
        if (clear) begin
            for (int i = 0; i < CH; i++) m_pend[k][i] = 0;
            m_drop[k] = 0;
        end
    endtask

    task automatic check_outputs();
        int et0, et1;
        et0 = 0; et1 = 0;
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("count_w[%0d]", i), int'(count_w[i*W +: W]), m_cnt[0][i]);
            chk($sformatf("count_s[%0d]", i), int'(count_s[i*W +: W]), m_cnt[1][i]);
            et0 |= int'(m_term[0][i]) << i;
            et1 |= int'(m_term[1][i]) << i;
        end
        chk("terminal_w", int'(term_w), et0);
        chk("terminal_s", int'(term_s), et1);
        chk("drop_w", int'(drop_w), m_drop[0]);
        chk("drop_s", int'(drop_s), m_drop[1]);
        chk("valid_w", int'(valid_w), int'(m_valid[0]));
        chk("valid_s", int'(valid_s), int'(m_valid[1]));
        if (m_valid[0]) begin
            chk("held_ch_w", int'(ch_w), m_och[0]);
            chk("held_dn_w", int'(dn_w), int'(m_odn[0]));
        end
        if (m_valid[1]) begin
            chk("held_ch_s", int'(ch_s), m_och[1]);
            chk("held_dn_s", int'(dn_s), int'(m_odn[1]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_count_w"}, int'(count_w != '0), 0);
        chk({tag, "_count_s"}, int'(count_s != '0), 0);
        chk({tag, "_term"}, int'(term_w) + int'(term_s), 0);
        chk({tag, "_valid"}, int'(valid_w) + int'(valid_s), 0);
        chk({tag, "_chan"}, int'(ch_w) + int'(ch_s), 0);
        chk({tag, "_down"}, int'(dn_w) + int'(dn_s), 0);
        chk({tag, "_drop"}, int'(drop_w) + int'(drop_s), 0);
    endtask

    // Monitor: each handshake pops the expected event for that instance.
    always @(negedge clk) begin
        if (rst_n && evt_ready) begin
            if (valid_w) begin
                if (exp_q0.size() == 0) chk("evt_w_unexpected", 1, 0);
                else chk("evt_w", int'(ch_w) * 2 + int'(dn_w), exp_q0.pop_front());
            end
            if (valid_s) begin
                if (exp_q1.size() == 0) chk("evt_s_unexpected", 1, 0);
                else chk("evt_s", int'(ch_s) * 2 + int'(dn_s), exp_q1.pop_front());
            end
        end
    end

    function automatic logic [W-1:0] pick_value();
        case ($urandom_range(0, 4))
            0: return 8'd0;
            1: return 8'd1;
            2: return 8'd254;
            3: return 8'd255;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Wrap through 255 -> 0 on channel 0.
        en = 4'b0001; down = '0; evt_ready = 1'b1;
        repeat (260) tick();
        chk("dir_wrap_count0", int'(count_w[7:0]), 4);
        chk("dir_sat_count0", int'(count_s[7:0]), 255);
        chk("dir_wrap_drop", int'(drop_w), 0);
        en = '0;
        repeat (3) tick();

        // Count down into zero with the consumer stalled.
        load = 4'b0010; load_value = '0; load_value[15:8] = 8'd2;
        tick();
        load = '0; down = 4'b0010; en = 4'b0010; evt_ready = 1'b0;
        repeat (5) tick();
        chk("dir_sat_count1", int'(count_s[15:8]), 0);
        chk("dir_sat_drop", int'(drop_s), 1);
        chk("dir_sat_valid", int'(valid_s), 1);
        chk("dir_sat_chan", int'(ch_s), 1);
        en = '0;
        repeat (3) tick();
        evt_ready = 1'b1;
        repeat (4) tick();

        // Simultaneous overflow on every channel, twice.
        down = '0;
        repeat (2) begin
            load = 4'hF; load_value = '1;
            tick();
            load = '0; en = 4'hF;
            tick();
            en = '0;
            repeat (6) tick();
        end

        // Load beats en at the boundary; clear beats en.
        load = 4'b0001; load_value = '0; load_value[7:0] = 8'd255;
        tick();
        load_value[7:0] = 8'd7; en = 4'b0001;
        tick();
        chk("dir_load_over_en", int'(count_w[7:0]), 7);
        chk("dir_load_no_term", int'(term_w), 0);
        load = '0; en = 4'hF; clear = 1'b1;
        tick();
        chk("dir_clear_count", int'(count_w != '0), 0);
        clear = 1'b0; en = '0;
        tick();

        // Clear while an event is held and others are pending.
        evt_ready = 1'b0; load = 4'hF; load_value = '1;
        tick();
        load = '0; en = 4'hF;
        tick();
        en = '0;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("dir_clear_keeps_valid", int'(valid_w), 1);
        chk("dir_clear_drop", int'(drop_s), 0);
        evt_ready = 1'b1;
        tick();
        chk("dir_clear_drained", int'(valid_w), 0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            en        = 4'($urandom);
            down      = 4'($urandom);
            load      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            for (int i = 0; i < CH; i++) load_value[i*W +: W] = pick_value();
            clear     = ($urandom_range(0, 99) == 0);
            evt_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        clear = 1'b0; load = '0;

        // Asynchronous reset with an event on the port.
        en = 4'b0100; down = '0; evt_ready = 1'b0; load = 4'b0100; load_value = '1;
        tick();
        load = '0;
        tick();
        en = 4'hF;
        repeat (2) tick();
        chk("pre_reset_valid", int'(valid_w), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        evt_ready = 1'b1; en = 4'b0011;
        repeat (20) tick();
        en = '0;
        repeat (10) tick();
        chk("queue_w_empty", exp_q0.size(), 0);
        chk("queue_s_empty", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
